// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop; valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] diff_next;

  always_comb begin
    d         = a_sr[0] ^ b_sr[0] ^ br;
    br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last      = (cnt == CW'(WIDTH - 1));
    // New result bit enters at the MSB so the LSB-first stream lands in place.
    diff_next = diff >> 1;
    diff_next[WIDTH-1] = d;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= diff_next;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bout  <= br_next;
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            ovf   <= br ^ br_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed and random WIDTH=8 traffic plus
// an exhaustive WIDTH=4 sweep running alongside on a second instance.
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst4 = 1'b1;

  logic       iv8, ir8, ov8, or8, bin8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       iv4, ir4, ov4, or4, bin4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bin4),
    .out_valid(ov4), .out_ready(or4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp8_q[$];
  logic [9:0] exp4_q[$];
  bit done4      = 1'b0;
  bit rand_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic. Packs {diff (8 bits, zero padded), bout, ovf}.
  function automatic logic [9:0] model(input int w, input int av, input int bv, input int bi);
    int full, sa, sb, sfull;
    logic [31:0] fv;
    logic [7:0]  dv;
    full  = av - bv - bi;
    sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb    = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sfull = sa - sb - bi;
    fv    = full;
    dv    = 8'(fv & ((1 << w) - 1));
    return {dv, full < 0, (sfull < -(1 << (w - 1))) || (sfull > (1 << (w - 1)) - 1)};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && ov8 && or8) begin
      check("excl8", ir8, 1'b0);
      if (exp8_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out8: diff=0x%0h with no expected entry", diff8);
      end else begin
        e = exp8_q.pop_front();
        check("diff8", diff8, e[9:2]);
        check("bout8", bout8, e[1]);
        check("ovf8",  ovf8,  e[0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst4 && ov4 && or4) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out4: diff=0x%0h with no expected entry", diff4);
      end else begin
        e = exp4_q.pop_front();
        check("diff4", diff4, e[5:2]);
        check("bout4", bout4, e[1]);
        check("ovf4",  ovf4,  e[0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int t;
    logic [9:0] e;
    t = 0;
    @(negedge clk);
    while (!ir8 && t < 100) begin @(negedge clk); t++; end
    if (!ir8) begin
      n_checks++;
      $display("FAIL send8_timeout: in_ready=%0b, expected 1", ir8);
      return;
    end
    a8 = av; b8 = bv; bin8 = bi; iv8 = 1'b1;
    @(posedge clk);
    e = model(8, av, bv, bi);
    exp8_q.push_back(e);
    #1;
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic send4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    int t;
    logic [9:0] e;
    t = 0;
    @(negedge clk);
    while (!ir4 && t < 100) begin @(negedge clk); t++; end
    if (!ir4) begin
      n_checks++;
      $display("FAIL send4_timeout: in_ready=%0b, expected 1", ir4);
      return;
    end
    a4 = av; b4 = bv; bin4 = bi; iv4 = 1'b1;
    @(posedge clk);
    e = model(4, av, bv, bi);
    exp4_q.push_back(e);
    #1;
    iv4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
  endtask

  // ---------------- WIDTH=4 exhaustive ----------------
  initial begin
    int t;
    iv4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; or4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst4 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      send4(v[8:5], v[4:1], v[0]);
    end
    t = 0;
    while (exp4_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    done4 = 1'b1;
  end

  // ---------------- WIDTH=8 directed + random ----------------
  initial begin
    int lat, t;
    logic seen;
    logic [9:0] e;
    iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_diff", diff8, 8'h00);
    check("rst_bout", bout8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_out_valid", ov8, 1'b0);
    check("rst_in_ready", ir8, 1'b1);

    // Basic case plus latency from the input handshake edge
    send8(8'h05, 8'h03, 1'b0);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov8 && lat < 40);
    check("latency", lat, 8);

    send8(8'h00, 8'h01, 1'b0);
    send8(8'h80, 8'h01, 1'b0);
    send8(8'h7F, 8'hFF, 1'b0);
    send8(8'h80, 8'h00, 1'b1);
    send8(8'h00, 8'hFF, 1'b1);

    // Backpressure: hold DONE for 5 cycles while in_valid toggles
    send8(8'h3C, 8'h5A, 1'b1);
    or8 = 1'b0;
    e = model(8, 8'h3C, 8'h5A, 1);
    t = 0;
    while (!ov8 && t < 40) begin @(posedge clk); #1; t++; end
    check("bp_reach_done", ov8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 iv8 = ~iv8;
      @(negedge clk);
      check("bp_diff", diff8, e[9:2]);
      check("bp_bout", bout8, e[1]);
      check("bp_ovf", ovf8, e[0]);
      check("bp_in_ready", ir8, 1'b0);
      check("bp_out_valid", ov8, 1'b1);
    end
    iv8 = 1'b0;
    @(posedge clk); #1 or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    @(negedge clk);
    check("bp_release_out_valid", ov8, 1'b0);
    check("bp_release_in_ready", ir8, 1'b1);
    or8 = 1'b1;

    // Reset three cycles into RUN: operation must vanish
    send8(8'h10, 8'h01, 1'b0);
    void'(exp8_q.pop_back());
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_diff", diff8, 8'h00);
    check("abort_bout", bout8, 1'b0);
    check("abort_ovf", ovf8, 1'b0);
    check("abort_in_ready", ir8, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (ov8) seen = 1'b1; end
    check("abort_no_out_valid", seen, 1'b0);
    send8(8'h10, 8'h01, 1'b0);

    // Random traffic with random output backpressure
    rand_phase = 1'b1;
    fork
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1 or8 = rand_phase ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    send8(8'hFF, 8'hFF, 1'b1);
    send8(8'h7F, 8'h80, 1'b0);
    rand_phase = 1'b0;
    repeat (3) @(posedge clk);
    #1 or8 = 1'b1;

    t = 0;
    while ((exp8_q.size() != 0 || !done4) && t < 6000) begin @(posedge clk); t++; end
    check("drain", {30'd0, exp8_q.size() == 0 && exp4_q.size() == 0, done4}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
